// File: rtl/oci_trace_capture_if.sv
// Trace-frame input strobe and read-port bundle for oci_trace_capture.
interface oci_trace_capture_if #(
    parameter int FRAME_W = 30,
    parameter int COUNT_W = 4
);
    logic                       dct_valid;
    logic [FRAME_W-1:0]         dct_buffer;
    logic [COUNT_W-1:0]         dct_count;
    logic                       rd_req;
    logic [FRAME_W+COUNT_W-1:0] rd_data;
    logic                       rd_valid;

    modport master (
        output dct_valid, dct_buffer, dct_count, rd_req,
        input  rd_data, rd_valid
    );

    modport slave (
        input  dct_valid, dct_buffer, dct_count, rd_req,
        output rd_data, rd_valid
    );
endinterface

// File: rtl/oci_trace_capture.sv
// Captures DCT trace frames into a FIFO, tracks the test-end handshake and
// serves stored frames on a registered one-cycle-latency read port.
module oci_trace_capture #(
    parameter int FRAME_W   = 30,
    parameter int COUNT_W   = 4,
    parameter int DEPTH     = 16,
    parameter int OVERWRITE = 0,
    parameter int OVF_W     = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    oci_trace_capture_if.slave      bus,
    input  logic                    test_ending,
    input  logic                    test_has_ended,
    output logic [$clog2(DEPTH):0]  level,
    output logic [OVF_W-1:0]        overflow_cnt,
    output logic [1:0]              state,
    output logic                    done
);
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int LVL_W   = PTR_W + 1;
    localparam int ENTRY_W = FRAME_W + COUNT_W;
    localparam bit OVW     = (OVERWRITE != 0);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DRAIN   = 2'd2,
        ENDED   = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [LVL_W-1:0]   level_q;

    logic accepting, frame_ok, full, empty, pop, wr_en, lost, drop_head;

    always_comb begin
        accepting = (state_q == IDLE) || (state_q == CAPTURE);
        frame_ok  = bus.dct_valid && (bus.dct_count != '0) && accepting && !test_has_ended;
        full      = (level_q == LVL_W'(DEPTH));
        empty     = (level_q == '0);
        pop       = bus.rd_req && !empty;
        // A pop in the same cycle frees a slot, so a full FIFO never loses a frame then.
        lost      = frame_ok && full && !pop;
        wr_en     = frame_ok && (!full || pop || OVW);
        drop_head = lost && OVW;
    end

    // NOTE: next state defaults to the current state first, so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (frame_ok)    state_d = CAPTURE;
            CAPTURE: if (test_ending) state_d = DRAIN;
            DRAIN:   if (empty && !bus.rd_valid) state_d = ENDED;
            default: state_d = ENDED;
        endcase
        if (test_has_ended) state_d = ENDED;
    end

    // NOTE: non-blocking assignments so every register updates from pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // NOTE: the storage array is not reset; pointers and level alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= {bus.dct_count, bus.dct_buffer};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level_q      <= '0;
            bus.rd_valid <= 1'b0;
            bus.rd_data  <= '0;
            overflow_cnt <= '0;
        end else begin
            bus.rd_valid <= pop;
            if (pop)               bus.rd_data <= mem[rd_ptr];
            if (wr_en)             wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop || drop_head)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (wr_en && !(pop || drop_head))
                level_q <= level_q + LVL_W'(1);
            else if (!wr_en && pop)
                level_q <= level_q - LVL_W'(1);
            if (lost && (overflow_cnt != '1))
                overflow_cnt <= overflow_cnt + OVF_W'(1);
        end
    end

    assign level = level_q;
    assign state = state_q;
    assign done  = (state_q == ENDED) && (level_q == '0);
endmodule

// File: tb/tb_oci_trace_capture.sv
// Self-checking bench: drop-newest and overwrite-oldest instances driven in
// lockstep, a FIFO reference model feeding read scoreboards, plus vector table.
module tb_oci_trace_capture;
    localparam int FRAME_W = 30;
    localparam int COUNT_W = 4;
    localparam int DEPTH   = 16;
    localparam int ENTRY_W = FRAME_W + COUNT_W;

    typedef logic [ENTRY_W-1:0] entry_t;

    typedef struct {
        bit                 v;
        logic [FRAME_W-1:0] payload;
        logic [COUNT_W-1:0] cnt;
        bit                 rd;
        logic [4:0]         exp_level;
        logic [1:0]         exp_state;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       test_ending, test_has_ended;
    logic [4:0] level_d, level_o;
    logic [15:0] ovf_d;
    logic [1:0] ovf_o;
    logic [1:0] state_d, state_o;
    logic       done_d, done_o;

    oci_trace_capture_if #(.FRAME_W(FRAME_W), .COUNT_W(COUNT_W)) bus_d ();
    oci_trace_capture_if #(.FRAME_W(FRAME_W), .COUNT_W(COUNT_W)) bus_o ();

    oci_trace_capture #(.FRAME_W(FRAME_W), .COUNT_W(COUNT_W), .DEPTH(DEPTH),
                        .OVERWRITE(0), .OVF_W(16)) u_drop (
        .clk(clk), .reset(reset), .bus(bus_d),
        .test_ending(test_ending), .test_has_ended(test_has_ended),
        .level(level_d), .overflow_cnt(ovf_d), .state(state_d), .done(done_d)
    );

    oci_trace_capture #(.FRAME_W(FRAME_W), .COUNT_W(COUNT_W), .DEPTH(DEPTH),
                        .OVERWRITE(1), .OVF_W(2)) u_ovr (
        .clk(clk), .reset(reset), .bus(bus_o),
        .test_ending(test_ending), .test_has_ended(test_has_ended),
        .level(level_o), .overflow_cnt(ovf_o), .state(state_o), .done(done_o)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Reference model: index 0 = drop newest, index 1 = overwrite oldest.
    entry_t m_mem [2][DEPTH];
    int     m_head [2];
    int     m_cnt  [2];
    int     m_ovf  [2];
    int     m_state;
    entry_t exp_d [$];
    entry_t exp_o [$];
    entry_t last_d, last_o;

    task automatic model_fifo(input int k, input bit ok, input bit rd, input entry_t e);
        bit popped;
        int ovf_max;
        popped  = rd && (m_cnt[k] > 0);
        ovf_max = (k == 0) ? 65535 : 3;
        if (popped) begin
            if (k == 0) exp_d.push_back(m_mem[k][m_head[k]]);
            else        exp_o.push_back(m_mem[k][m_head[k]]);
            m_head[k] = (m_head[k] + 1) % DEPTH;
            m_cnt[k]--;
        end
        if (ok) begin
            if (m_cnt[k] == DEPTH) begin
                if (m_ovf[k] < ovf_max) m_ovf[k]++;
                if (k == 1) begin
                    m_head[k] = (m_head[k] + 1) % DEPTH;
                    m_cnt[k]--;
                end
            end
            if (m_cnt[k] < DEPTH) begin
                m_mem[k][(m_head[k] + m_cnt[k]) % DEPTH] = e;
                m_cnt[k]++;
            end
        end
    endtask

    task automatic drive(input bit v, input logic [FRAME_W-1:0] payload, input logic [COUNT_W-1:0] cnt,
                         input bit rd, input bit te, input bit the);
        bus_d.dct_valid = v;  bus_d.dct_buffer = payload; bus_d.dct_count = cnt; bus_d.rd_req = rd;
        bus_o.dct_valid = v;  bus_o.dct_buffer = payload; bus_o.dct_count = cnt; bus_o.rd_req = rd;
        test_ending    = te;
        test_has_ended = the;
    endtask

    // One clock: drive inputs, advance the model, then compare levels/counters/state.
    task automatic step(input bit v, input logic [FRAME_W-1:0] payload, input logic [COUNT_W-1:0] cnt,
                        input bit rd, input bit te, input bit the);
        bit     ok;
        entry_t e;
        e  = {cnt, payload};
        ok = v && (cnt != '0) && (m_state <= 1) && !the;
        drive(v, payload, cnt, rd, te, the);
        model_fifo(0, ok, rd, e);
        model_fifo(1, ok, rd, e);
        if (the)                     m_state = 3;
        else if (m_state == 0 && ok) m_state = 1;
        else if (m_state == 1 && te) m_state = 2;
        @(posedge clk);
        #1;
        check("level_d", level_d, m_cnt[0]);
        check("level_o", level_o, m_cnt[1]);
        check("ovf_d", ovf_d, m_ovf[0]);
        check("ovf_o", ovf_o, m_ovf[1]);
        if (m_state != 2) begin
            check("state_d", state_d, m_state);
            check("state_o", state_o, m_state);
        end
    endtask

    task automatic pending_check(input string tag);
        check({tag, " pending_d"}, exp_d.size(), 0);
        check({tag, " pending_o"}, exp_o.size(), 0);
    endtask

    task automatic apply_reset();
        drive(0, '0, '0, 0, 0, 0);
        #2 reset = 1'b1;
        #1;
        check("rst level_d", level_d, 0);
        check("rst level_o", level_o, 0);
        check("rst state_d", state_d, 0);
        check("rst ovf_d", ovf_d, 0);
        check("rst ovf_o", ovf_o, 0);
        check("rst rd_valid_d", bus_d.rd_valid, 0);
        check("rst rd_valid_o", bus_o.rd_valid, 0);
        check("rst done_d", done_d, 0);
        for (int k = 0; k < 2; k++) begin
            m_head[k] = 0; m_cnt[k] = 0; m_ovf[k] = 0;
        end
        m_state = 0;
        exp_d.delete();
        exp_o.delete();
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Read scoreboards: every rd_valid must match the oldest expected entry.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus_d.rd_valid) begin
                if (exp_d.size() == 0) check("rd_valid_d spurious", bus_d.rd_valid, 1'b0);
                else begin
                    last_d = exp_d.pop_front();
                    check("rd_data_d", bus_d.rd_data, last_d);
                end
            end
            if (bus_o.rd_valid) begin
                if (exp_o.size() == 0) check("rd_valid_o spurious", bus_o.rd_valid, 1'b0);
                else begin
                    last_o = exp_o.pop_front();
                    check("rd_data_o", bus_o.rd_data, last_o);
                end
            end
        end
    end

    initial begin
        vec_t vecs [13];
        int   waited;

        vecs[0]  = '{1'b1, 30'h1,  4'd4, 1'b0, 5'd1, 2'd1};
        vecs[1]  = '{1'b1, 30'h2,  4'd4, 1'b0, 5'd2, 2'd1};
        vecs[2]  = '{1'b1, 30'h3,  4'd4, 1'b0, 5'd3, 2'd1};
        vecs[3]  = '{1'b1, 30'h3F, 4'd0, 1'b0, 5'd3, 2'd1};
        vecs[4]  = '{1'b0, 30'h0,  4'd0, 1'b1, 5'd2, 2'd1};
        vecs[5]  = '{1'b0, 30'h0,  4'd0, 1'b1, 5'd1, 2'd1};
        vecs[6]  = '{1'b0, 30'h0,  4'd0, 1'b1, 5'd0, 2'd1};
        vecs[7]  = '{1'b0, 30'h0,  4'd0, 1'b1, 5'd0, 2'd1};
        vecs[8]  = '{1'b0, 30'h0,  4'd0, 1'b0, 5'd0, 2'd1};
        vecs[9]  = '{1'b1, 30'h5,  4'd2, 1'b1, 5'd1, 2'd1};
        vecs[10] = '{1'b0, 30'h0,  4'd0, 1'b1, 5'd0, 2'd1};
        vecs[11] = '{1'b0, 30'h0,  4'd0, 1'b1, 5'd0, 2'd1};
        vecs[12] = '{1'b0, 30'h0,  4'd0, 1'b0, 5'd0, 2'd1};

        reset = 1'b1;
        drive(0, '0, '0, 0, 0, 0);
        for (int k = 0; k < 2; k++) begin
            m_head[k] = 0; m_cnt[k] = 0; m_ovf[k] = 0;
        end
        m_state = 0;
        repeat (2) @(posedge clk);
        #1;
        check("init level_d", level_d, 0);
        check("init state_o", state_o, 0);
        check("init rd_data_d", bus_d.rd_data, 0);
        check("init rd_valid_o", bus_o.rd_valid, 0);
        check("init done_o", done_o, 0);
        reset = 1'b0;

        // Basic write/read, zero-count frame, empty read, write+read while empty.
        for (int i = 0; i < 13; i++) begin
            step(vecs[i].v, vecs[i].payload, vecs[i].cnt, vecs[i].rd, 0, 0);
            check($sformatf("vec%0d level_d", i), level_d, vecs[i].exp_level);
            check($sformatf("vec%0d level_o", i), level_o, vecs[i].exp_level);
            check($sformatf("vec%0d state_d", i), state_d, vecs[i].exp_state);
        end
        check("rd_data hold_d", bus_d.rd_data, {4'd2, 30'h5});
        check("rd_valid empty_d", bus_d.rd_valid, 1'b0);
        pending_check("basic");

        // Reset in the middle of capture with 5 entries stored.
        for (int i = 0; i < 5; i++) step(1, 30'(i + 1), 4'd7, 0, 0, 0);
        check("pre-reset level_d", level_d, 5);
        apply_reset();

        // Overflow: 18 writes into a 16-deep FIFO.
        for (int i = 1; i <= 18; i++) step(1, 30'(i), 4'd1, 0, 0, 0);
        check("ovf level_d", level_d, 16);
        check("ovf level_o", level_o, 16);
        check("ovf cnt_d", ovf_d, 2);
        check("ovf cnt_o", ovf_o, 2);
        check("ovf head_o model", m_mem[1][m_head[1]], {4'd1, 30'd3});
        for (int i = 0; i < 16; i++) step(0, '0, '0, 1, 0, 0);
        step(0, '0, '0, 0, 0, 0);
        check("ovf last_d", last_d, {4'd1, 30'd16});
        check("ovf last_o", last_o, {4'd1, 30'd18});
        pending_check("overflow");

        // Full FIFO with simultaneous write and read, then counter saturation.
        for (int i = 1; i <= 16; i++) step(1, 30'(32'h100 + i), 4'd3, 0, 0, 0);
        step(1, 30'h200, 4'd3, 1, 0, 0);
        check("full wr+rd level_d", level_d, 16);
        check("full wr+rd level_o", level_o, 16);
        check("full wr+rd ovf_d", ovf_d, 2);
        check("full wr+rd ovf_o", ovf_o, 2);
        for (int i = 0; i < 3; i++) step(1, 30'(32'h300 + i), 4'd3, 0, 0, 0);
        check("sat ovf_d", ovf_d, 5);
        check("sat ovf_o", ovf_o, 3);
        pending_check("full");
        apply_reset();

        // test_ending with a same-cycle frame, then drain with dct_valid held high.
        step(1, 30'hA, 4'd5, 0, 0, 0);
        step(1, 30'hB, 4'd5, 0, 1, 0);
        check("drain state_d", state_d, 2);
        check("drain state_o", state_o, 2);
        check("drain level_d", level_d, 2);
        step(1, 30'hC, 4'd5, 1, 0, 0);
        step(1, 30'hD, 4'd5, 1, 0, 0);
        check("drain done_early_d", done_d, 0);
        waited = 0;
        while ((state_d != 2'd3 || state_o != 2'd3) && waited < 8) begin
            step(1, 30'hE, 4'd5, 0, 0, 0);
            waited++;
        end
        check("drain reached ENDED_d", state_d, 3);
        check("drain reached ENDED_o", state_o, 3);
        m_state = 3;
        check("drain done_d", done_d, 1);
        check("drain done_o", done_o, 1);
        check("drain last_d", last_d, {4'd5, 30'hB});
        pending_check("drain");
        apply_reset();

        // test_has_ended in CAPTURE discards the same-cycle frame; reads still work.
        step(1, 30'h11, 4'd2, 0, 0, 0);
        step(1, 30'h22, 4'd2, 0, 0, 1);
        check("hard end state_d", state_d, 3);
        check("hard end level_d", level_d, 1);
        check("hard end done_d", done_d, 0);
        step(1, 30'h33, 4'd2, 1, 1, 0);
        check("hard end done_d after read", done_d, 1);
        check("hard end done_o after read", done_o, 1);
        step(0, '0, '0, 0, 0, 0);
        check("hard end last_o", last_o, {4'd2, 30'h11});
        check("ended terminal state_o", state_o, 3);
        pending_check("hard end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/oci_trace_capture.md
Name: oci_trace_capture

Overview:
- Parametrised successor to the CPU OCI test-bench monitor.
- Captures debug compressed-trace (DCT) frames, each a `dct_buffer` word plus `dct_count`, into an internal FIFO.
- Tracks the test-end handshake (`test_ending` / `test_has_ended`) through a small state machine.
- Exposes captured frames on a one-cycle-latency read port for bench scoreboards or a JTAG-side drain.

Parameters:
- FRAME_W, 30, width of dct_buffer.
- COUNT_W, 4, width of dct_count.
- DEPTH, 16, FIFO entries; power of two, >= 2.
- OVERWRITE, 0, full policy: 0 = drop newest frame, 1 = overwrite oldest entry.
- OVF_W, 16, width of the saturating overflow counter.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- dct_valid  input  1  frame strobe; dct_buffer/dct_count sampled when high.
- dct_buffer  input  FRAME_W  trace payload.
- dct_count  input  COUNT_W  number of valid slots in payload; 0 = empty frame.
- test_ending  input  1  request to stop capture and drain.
- test_has_ended  input  1  hard end of test.
- rd_req  input  1  pop one entry.
- rd_data  output  FRAME_W+COUNT_W  {dct_count, dct_buffer} of popped entry.
- rd_valid  output  1  rd_data valid this cycle.
- level  output  $clog2(DEPTH)+1  current FIFO occupancy.
- overflow_cnt  output  OVF_W  frames lost or overwritten; saturating.
- state  output  2  0 IDLE, 1 CAPTURE, 2 DRAIN, 3 ENDED.
- done  output  1  high when state==ENDED and level==0.

Behaviour:
- Reset (async assert, sync-safe deassert): state=IDLE, pointers=0, level=0, rd_data=0, rd_valid=0, overflow_cnt=0, done=0.
- Frame acceptance: a frame is accepted only when dct_valid=1, dct_count!=0, and state is IDLE or CAPTURE.
- Frames with dct_count=0 are ignored and never counted as overflow.
- IDLE -> CAPTURE: on the first accepted frame; that frame is written in the same cycle.
- CAPTURE -> DRAIN: on test_ending=1. Any frame presented in the same cycle is still written; later frames are ignored.
- DRAIN -> ENDED: when level==0 and no read is in flight.
- test_has_ended=1 in any state forces ENDED next cycle; a frame presented in that cycle is discarded.
- ENDED is terminal until reset. Reads remain legal in all states.
- Read port:
  - rd_req with level>0 pops the head; rd_data/rd_valid are registered and appear next cycle.
  - rd_valid is high for exactly one cycle per pop.
  - rd_req with level==0 is ignored: rd_valid=0 and rd_data holds its last value.
- Simultaneous write and read:
  - Both are accepted and level is unchanged. This holds when full.
  - When empty, the read is ignored and only the write occurs.
- Full with no read, OVERWRITE=0: the new frame is dropped and overflow_cnt increments.
- Full with no read, OVERWRITE=1: the new frame is written at the tail, the head advances (oldest lost), level stays DEPTH, and overflow_cnt increments.
- overflow_cnt saturates at all-ones.
- Pointers are log2(DEPTH) bits and wrap naturally. level is computed exactly, 0..DEPTH inclusive.
- done is combinational from registered state and level.

Test Plan:
- Reset mid-capture with 5 entries stored -> next cycle level=0, state=0, overflow_cnt=0, rd_valid=0.
- Write frames 0x1..0x3 with dct_count=4 plus one frame with dct_count=0, then 3 rd_req -> rd_data={4,0x1},{4,0x2},{4,0x3} one cycle after each req; level ends 0; the zero-count frame is never stored.
- DEPTH=16, OVERWRITE=0, write 18 frames -> level=16, overflow_cnt=2, reads return frames 1..16.
- OVERWRITE=1, write 18 frames -> overflow_cnt=2, reads return frames 3..18.
- Full FIFO, write plus rd_req in the same cycle -> level stays 16, overflow_cnt unchanged.
- Assert test_ending with 2 entries, keep dct_valid high -> state=DRAIN, no new writes; after 2 reads state=ENDED, done=1. Separately, test_has_ended while in CAPTURE -> state=ENDED next cycle, same-cycle frame discarded.
